// File: rtl/rf_pkg.sv
// rf_pkg: shared types, constants and helpers for the multi-port register file.
package rf_pkg;
  typedef enum logic {IDLE, CLEAR} rf_state_e;
  localparam int ZERO_ADDR = 0;
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rf_clear_seq.sv
// rf_clear_seq: clear engine that walks every entry once after reset or a clear request.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req_i,
  output logic          busy_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o
);
  rf_state_e     state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic          last;
  assign last = clr_idx_q == AW'(NREGS - 1);
  always_comb begin
    state_d   = (state_q == CLEAR) ? (last ? IDLE : CLEAR) : (clr_req_i ? CLEAR : IDLE);
    clr_idx_d = (state_q == CLEAR && !last) ? clr_idx_q + AW'(1) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end
  // Reset itself counts as busy so user traffic is blocked in the reset cycles too.
  assign busy_o     = reset || state_q == CLEAR;
  assign clr_we_o   = state_q == CLEAR;
  assign clr_addr_o = clr_idx_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with x0, bypass and a clear engine.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int  XLEN     = 64,
  parameter int  NREGS    = 32,
  parameter int  NRD      = 2,
  parameter int  NWR      = 1,
  parameter int  ZERO_REG = 1,
  parameter int  BYPASS   = 1,
  localparam int AW       = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                clr_req,
  output logic                busy
);
  logic [XLEN-1:0] mem_q [NREGS];
  logic [AW-1:0]   wa [NWR];
  logic [XLEN-1:0] wd [NWR];
  logic [NWR-1:0]  wok;
  logic            clr_we;
  logic [AW-1:0]   clr_addr;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < (AW+1)'(NREGS)) && !(ZERO_REG != 0 && a == AW'(ZERO_ADDR));
  endfunction

  rf_clear_seq #(.NREGS(NREGS), .AW(AW)) u_seq (
    .clk       (clk),
    .reset     (reset),
    .clr_req_i (clr_req),
    .busy_o    (busy),
    .clr_we_o  (clr_we),
    .clr_addr_o(clr_addr)
  );

  for (genvar g = 0; g < NWR; g++) begin : g_wr
    assign wa[g]  = wr_addr[g*AW +: AW];
    assign wd[g]  = wr_data[g*XLEN +: XLEN];
    assign wok[g] = wr_en[g] && !busy && addr_ok(wa[g]);
  end

  // Later ports overwrite earlier ones, so the highest-index port wins a collision.
  always_ff @(posedge clk) begin
    if (clr_we) mem_q[clr_addr] <= '0;
    else for (int j = 0; j < NWR; j++) if (wok[j]) mem_q[wa[j]] <= wd[j];
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] v;
    assign a = rd_addr[i*AW +: AW];
    always_comb begin
      v = mem_q[a];
      for (int j = 0; j < NWR; j++) if (BYPASS != 0 && wok[j] && wa[j] == a) v = wd[j];
    end
    assign rd_data[i*XLEN +: XLEN] = (busy || !addr_ok(a)) ? '0 : v;
  end
endmodule
